timing_recovery_gen: RTL

- Parametrised successor to the fixed 4-bit, 16x timing-recovery loop.
- Takes oversampled signed I/Q from the demod front end at the sample clock and runs a Gardner timing-error detector on both channels.
- A first-order accumulate-and-threshold loop steps the sampling phase tau.
- Emits a one-cycle symbol strobe with the recovered I/Q, the per-symbol error, the current tau, and a lock flag for the packet detector.

---
 rtl/timing_recovery_gen_if.sv | 27 ++
 rtl/timing_recovery_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/timing_recovery_gen_if.sv
// Sample-stream bundle between the demod front end and the timing-recovery loop.
// The front end is the master: it drives the samples and reads back the recovered symbols.
interface timing_recovery_gen_if #(
  parameter int W     = 4,
  parameter int TAU_W = 4,
  parameter int ERR_W = 8
);
  logic                    en;
  logic signed [W-1:0]     I_in;
  logic signed [W-1:0]     Q_in;
  logic                    sym_valid;
  logic signed [W-1:0]     sym_I;
  logic signed [W-1:0]     sym_Q;
  logic signed [ERR_W-1:0] e_k_out;
  logic [TAU_W-1:0]        tau_out;
  logic                    locked;

  modport master (
    output en, I_in, Q_in,
    input  sym_valid, sym_I, sym_Q, e_k_out, tau_out, locked
  );

  modport slave (
    input  en, I_in, Q_in,
    output sym_valid, sym_I, sym_Q, e_k_out, tau_out, locked
  );
endinterface

// File: rtl/timing_recovery_gen.sv
// Gardner timing-error detector on I/Q with a first-order accumulate-and-threshold
// loop that nudges the symbol phase tau by one sample whenever the accumulated
// error crosses +/-THRESH. A lock flag rises after LOCK_SYMS step-free symbols.
module timing_recovery_gen #(
  parameter int W         = 4,
  parameter int OSR       = 16,
  parameter int TAU_W     = $clog2(OSR),
  parameter int ERR_W     = 8,
  parameter int ACC_W     = 12,
  parameter int THRESH    = 64,
  parameter int LOCK_SYMS = 32
) (
  input logic                  clk,
  input logic                  rst,
  timing_recovery_gen_if.slave bus
);
  localparam int CNT_W = $clog2(OSR + 1);
  localparam int LCK_W = $clog2(LOCK_SYMS + 1);
  localparam int PW    = 2 * W + 2;
  localparam logic signed [ACC_W-1:0] TH_POS = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] TH_NEG = ACC_W'(-THRESH);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TAU_W-1:0]        tau_q, tau_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LCK_W-1:0]        lock_q, lock_d;
  logic                    first_q, first_d;
  logic signed [W-1:0]     mid_i_q, mid_i_d, mid_q_q, mid_q_d;
  logic signed [W-1:0]     prev_i_q, prev_i_d, prev_q_q, prev_q_d;
  logic                    sym_valid_q, sym_valid_d;
  logic signed [W-1:0]     sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic signed [ERR_W-1:0] err_q, err_d;

  logic                    strobe, mid_hit, step_up, step_dn;
  logic signed [PW-1:0]    diff_i, diff_q, e_full;
  logic signed [ERR_W-1:0] err_sat;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_n;

  assign strobe  = bus.en && (cnt_q == '0);
  assign mid_hit = bus.en && (cnt_q == CNT_W'(OSR / 2));

  // Full-width Gardner error: mid * (prev - cur) summed over I and Q.
  always_comb begin
    diff_i = PW'(prev_i_q) - PW'(bus.I_in);
    diff_q = PW'(prev_q_q) - PW'(bus.Q_in);
    e_full = (PW'(mid_i_q) * diff_i) + (PW'(mid_q_q) * diff_q);
  end

  generate
    if (ERR_W < PW) begin : g_err_sat
      // Clamp the raw error when its upper bits are not a pure sign extension.
      always_comb begin
        if ((e_full[PW-1:ERR_W-1] == '0) || (e_full[PW-1:ERR_W-1] == '1))
          err_sat = e_full[ERR_W-1:0];
        else if (e_full[PW-1])
          err_sat = {1'b1, {(ERR_W-1){1'b0}}};
        else
          err_sat = {1'b0, {(ERR_W-1){1'b1}}};
      end
    end else begin : g_err_ext
      assign err_sat = ERR_W'(e_full);
    end
  endgenerate

  // Accumulate one guard bit wide, then clamp back so the loop never wraps.
  always_comb begin
    acc_sum = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(err_sat);
    if (acc_sum[ACC_W] == acc_sum[ACC_W-1])
      acc_n = acc_sum[ACC_W-1:0];
    else if (acc_sum[ACC_W])
      acc_n = {1'b1, {(ACC_W-1){1'b0}}};
    else
      acc_n = {1'b0, {(ACC_W-1){1'b1}}};
    step_up = !first_q && (acc_n >= TH_POS);
    step_dn = !first_q && (acc_n <= TH_NEG);
  end

  // Next-state: counter, mid/strobe captures, loop filter, tau stepping and lock.
  always_comb begin
    cnt_d       = cnt_q;
    tau_d       = tau_q;
    acc_d       = acc_q;
    lock_d      = lock_q;
    first_d     = first_q;
    mid_i_d     = mid_i_q;
    mid_q_d     = mid_q_q;
    prev_i_d    = prev_i_q;
    prev_q_d    = prev_q_q;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    err_d       = err_q;
    sym_valid_d = strobe;
    if (bus.en) begin
      cnt_d = cnt_q - 1'b1;
      if (mid_hit) begin
        mid_i_d = bus.I_in;
        mid_q_d = bus.Q_in;
      end
      if (strobe) begin
        sym_i_d  = bus.I_in;
        sym_q_d  = bus.Q_in;
        err_d    = err_sat;
        prev_i_d = bus.I_in;
        prev_q_d = bus.Q_in;
        if (first_q) begin
          first_d = 1'b0;
          cnt_d   = CNT_W'(OSR - 1);
        end else if (step_up) begin
          tau_d  = (tau_q == TAU_W'(OSR - 1)) ? '0 : tau_q + 1'b1;
          acc_d  = '0;
          lock_d = '0;
          cnt_d  = CNT_W'(OSR);
        end else if (step_dn) begin
          tau_d  = (tau_q == '0) ? TAU_W'(OSR - 1) : tau_q - 1'b1;
          acc_d  = '0;
          lock_d = '0;
          cnt_d  = CNT_W'(OSR - 2);
        end else begin
          acc_d = acc_n;
          cnt_d = CNT_W'(OSR - 1);
          if (lock_q != LCK_W'(LOCK_SYMS))
            lock_d = lock_q + 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= CNT_W'(OSR - 1);
      tau_q       <= '0;
      acc_q       <= '0;
      lock_q      <= '0;
      first_q     <= 1'b1;
      mid_i_q     <= '0;
      mid_q_q     <= '0;
      prev_i_q    <= '0;
      prev_q_q    <= '0;
      sym_valid_q <= 1'b0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      err_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      tau_q       <= tau_d;
      acc_q       <= acc_d;
      lock_q      <= lock_d;
      first_q     <= first_d;
      mid_i_q     <= mid_i_d;
      mid_q_q     <= mid_q_d;
      prev_i_q    <= prev_i_d;
      prev_q_q    <= prev_q_d;
      sym_valid_q <= sym_valid_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      err_q       <= err_d;
    end
  end

  assign bus.sym_valid = sym_valid_q;
  assign bus.sym_I     = sym_i_q;
  assign bus.sym_Q     = sym_q_q;
  assign bus.e_k_out   = err_q;
  assign bus.tau_out   = tau_q;
  assign bus.locked    = (lock_q == LCK_W'(LOCK_SYMS));
endmodule
